serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..255.
REQ-002 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits, 0 omits it.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: synchronous, active-low (0 = reset), sampled on rising clk.
REQ-005 Port tx_data  input  8: byte to transmit, sampled only on an accepted handshake.
REQ-006 Port tx_valid  input  1: upstream offers tx_data.
REQ-007 Port tx_ready  output  1: block can accept a byte this cycle.
REQ-008 Port dout  output  1: serial line, idle high; feeds the downstream flip-flop stage's din.
REQ-009 Port busy  output  1: high while a frame is on the line.
REQ-010 Port frame_done  output  1: one-cycle pulse in the last cycle of the stop bit.

Function
REQ-011 Handshake: a byte is accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_data is latched into an internal shift register at that edge.
REQ-012 tx_ready shall be 1 only in IDLE; no new byte is accepted while busy=1.
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START on accept; START -> DATA after CLKS_PER_BIT cycles; DATA -> PARITY (PARITY_EN=1) or STOP (PARITY_EN=0) after 8 bit periods; PARITY -> STOP after one bit period; STOP -> IDLE after one bit period.
REQ-015 Line levels: IDLE 1, START 0, DATA bits LSB first, PARITY = XOR of the 8 latched bits, STOP 1.
REQ-016 Latency: dout leaves idle in the cycle immediately after the accepting edge.
REQ-017 Each bit is held for exactly CLKS_PER_BIT cycles; frame length is CLKS_PER_BIT*11 cycles with parity, CLKS_PER_BIT*10 without.
REQ-018 dout, busy, tx_ready and frame_done shall be registered outputs with no combinational path from inputs.
REQ-019 busy=1 in START, DATA, PARITY and STOP; busy=0 in IDLE.
REQ-020 After STOP, at least one IDLE cycle (dout=1, tx_ready=1) precedes the next START.
REQ-021 Changes to tx_data or tx_valid during a frame shall not affect the frame in progress.
REQ-022 CLKS_PER_BIT=1 shall produce one cycle per bit with no gaps or skipped bits.
REQ-023 Bit-period counter width is $clog2(CLKS_PER_BIT+1); the counter wraps to 0 at each bit boundary.

Reset
REQ-024 While reset=0 at a rising edge: state IDLE, dout=1, busy=0, frame_done=0, tx_ready=0, counters and shift register cleared.
REQ-025 First cycle after reset returns to 1: tx_ready=1.
REQ-026 Reset asserted mid-frame aborts the frame; dout=1 from the next cycle, and no frame_done pulse is produced for the aborted frame.

Structure
REQ-027 Shared package serial_pkg holds the state encoding, the idle line level (1) and the default CLKS_PER_BIT.
REQ-028 One sub-module, bit_tick_gen, generates the bit-period tick from CLKS_PER_BIT with clear-on-reset and restart-on-accept.
REQ-029 The FSM, shift register and parity logic reside in serial_frame_tx.

Verification
REQ-030 CLKS_PER_BIT=4, PARITY_EN=1, send 0xA5 -> dout per 4-cycle period: 0,1,0,1,0,0,1,0,1,0(parity),1; frame_done high in cycle 44 after accept; tx_ready=1 in cycle 45.
REQ-031 Send 0x07 with PARITY_EN=1 -> parity bit 1; with PARITY_EN=0 -> no parity bit, frame is 40 cycles.
REQ-032 Hold tx_valid=1 continuously with 0x3C then 0xC3 -> two complete frames separated by exactly 1 idle cycle; 0xC3 is accepted only on that idle cycle.
REQ-033 Toggle tx_data every cycle during a frame of 0x55 -> transmitted bits still match 0x55.
REQ-034 Drive reset=0 during DATA bit 3 -> next cycle dout=1, busy=0, tx_ready=0; no frame_done pulse; first cycle after reset release tx_ready=1.
REQ-035 CLKS_PER_BIT=1, send 0xFF -> 11-cycle frame: 0, eight 1s, parity 0, stop 1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter: FSM encoding,
// idle line level, default bit period and the parity helper.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 32'd4;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        even_parity = ^data;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period counter: tick_o marks the last cycle of each bit period,
// pre_tick_o marks the cycle whose successor is the last of a period.
module bit_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 32'd4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    input  logic en_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT - 2) : 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o     = (cnt_q == LAST);
    // With one cycle per bit every cycle is the last one of its period.
    assign pre_tick_o = (CLKS_PER_BIT == 1) ? 1'b1 : (cnt_q == PRE);

    // Next count: restart, wrap at the bit boundary, or park at zero when idle.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous active-low clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 8 data bits LSB first, optional
// even parity, stop bit. All outputs come straight from flip-flops.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       dout,
    output logic       busy,
    output logic       frame_done
);

    state_t     state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_idx_q;
    logic       parity_q;
    logic       dout_q;
    logic       busy_q;
    logic       tx_ready_q;
    logic       frame_done_q;

    logic accept_s;
    logic tick_s;
    logic pre_tick_s;
    logic next_is_stop_s;
    logic frame_done_d;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk_i     (clk),
        .rst_ni    (reset),
        .restart_i (accept_s),
        .en_i      (busy_q),
        .tick_o    (tick_s),
        .pre_tick_o(pre_tick_s)
    );

    // Handshake decode and look-ahead for the final stop-bit cycle.
    always_comb begin
        accept_s       = (state_q == ST_IDLE) && tx_valid && tx_ready_q;
        next_is_stop_s = 1'b0;
        if (state_q == ST_PARITY) begin
            next_is_stop_s = 1'b1;
        end else if ((state_q == ST_DATA) && (bit_idx_q == 3'd7) && (PARITY_EN == 1'b0)) begin
            next_is_stop_s = 1'b1;
        end else begin
            next_is_stop_s = 1'b0;
        end
        // Raise frame_done so that it lands exactly on the last stop-bit cycle.
        if (tick_s) begin
            frame_done_d = pre_tick_s && next_is_stop_s;
        end else begin
            frame_done_d = pre_tick_s && (state_q == ST_STOP);
        end
    end

    // Frame FSM with shift register and registered line/status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= 8'h00;
            bit_idx_q    <= 3'd0;
            parity_q     <= 1'b0;
            dout_q       <= LINE_IDLE;
            busy_q       <= 1'b0;
            tx_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q    <= ST_START;
                        shift_q    <= tx_data;
                        parity_q   <= even_parity(tx_data);
                        bit_idx_q  <= 3'd0;
                        dout_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        tx_ready_q <= 1'b0;
                    end else begin
                        dout_q     <= LINE_IDLE;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        state_q   <= ST_DATA;
                        dout_q    <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY_EN) begin
                                state_q <= ST_PARITY;
                                dout_q  <= parity_q;
                            end else begin
                                state_q <= ST_STOP;
                                dout_q  <= LINE_IDLE;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            dout_q    <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_s) begin
                        state_q <= ST_STOP;
                        dout_q  <= LINE_IDLE;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        state_q    <= ST_IDLE;
                        dout_q     <= LINE_IDLE;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    dout_q     <= LINE_IDLE;
                    busy_q     <= 1'b0;
                    tx_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready   = tx_ready_q;
    assign dout       = dout_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: three instances cover 4 clk/bit with
// and without parity, and 1 clk/bit with parity.
module tb_serial_frame_tx;

    logic clk = 1'b0;
    logic reset;

    logic [7:0] a_data, b_data, c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, b_ready, c_ready;
    logic       a_dout, b_dout, c_dout;
    logic       a_busy, b_busy, c_busy;
    logic       a_done, b_done, c_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .dout(a_dout), .busy(a_busy), .frame_done(a_done));

    serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .dout(b_dout), .busy(b_busy), .frame_done(b_done));

    serial_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1)) dut_c (
        .clk(clk), .reset(reset), .tx_data(c_data), .tx_valid(c_valid),
        .tx_ready(c_ready), .dout(c_dout), .busy(c_busy), .frame_done(c_done));

    // Observed/expected nibbles are {dout, frame_done, busy, tx_ready}.
    task automatic test_reset();
        logic [3:0] want;
        reset = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_data = 8'h00; b_data = 8'h00; c_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        want = 4'b1000;
        tests++;
        if ({a_dout, a_done, a_busy, a_ready} !== want) begin
            fails++;
            $display("FAIL reset_a: got %b required %b", {a_dout, a_done, a_busy, a_ready}, want);
        end
        tests++;
        if ({b_dout, b_done, b_busy, b_ready} !== want) begin
            fails++;
            $display("FAIL reset_b: got %b required %b", {b_dout, b_done, b_busy, b_ready}, want);
        end
        tests++;
        if ({c_dout, c_done, c_busy, c_ready} !== want) begin
            fails++;
            $display("FAIL reset_c: got %b required %b", {c_dout, c_done, c_busy, c_ready}, want);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        want = 4'b1001;
        tests++;
        if ({a_dout, a_done, a_busy, a_ready, b_ready, c_ready} !== {want, 2'b11}) begin
            fails++;
            $display("FAIL reset_release: got %b required %b",
                     {a_dout, a_done, a_busy, a_ready, b_ready, c_ready}, {want, 2'b11});
        end
    endtask

    task automatic test_frame_a5();
        logic [10:0] bits;
        logic [3:0]  want;
        bits = {1'b1, 1'b0, 8'hA5, 1'b0};
        a_data = 8'hA5; a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0; a_data = 8'h00;
        for (int n = 1; n <= 45; n++) begin
            if (n <= 44) want = {bits[(n - 1) / 4], (n == 44), 1'b1, 1'b0};
            else         want = 4'b1001;
            tests++;
            if ({a_dout, a_done, a_busy, a_ready} !== want) begin
                fails++;
                $display("FAIL frame_a5 cycle %0d: got %b required %b", n, {a_dout, a_done, a_busy, a_ready}, want);
            end
            if (n < 45) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_parity_07();
        logic [10:0] bits_a;
        logic [9:0]  bits_b;
        logic [3:0]  want;
        bits_a = {1'b1, 1'b1, 8'h07, 1'b0};
        bits_b = {1'b1, 8'h07, 1'b0};
        a_data = 8'h07; a_valid = 1'b1;
        b_data = 8'h07; b_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            if (n <= 44) want = {bits_a[(n - 1) / 4], (n == 44), 1'b1, 1'b0};
            else         want = 4'b1001;
            tests++;
            if ({a_dout, a_done, a_busy, a_ready} !== want) begin
                fails++;
                $display("FAIL parity_07 cycle %0d: got %b required %b", n, {a_dout, a_done, a_busy, a_ready}, want);
            end
            if (n <= 40) want = {bits_b[(n - 1) / 4], (n == 40), 1'b1, 1'b0};
            else         want = 4'b1001;
            tests++;
            if ({b_dout, b_done, b_busy, b_ready} !== want) begin
                fails++;
                $display("FAIL noparity_07 cycle %0d: got %b required %b", n, {b_dout, b_done, b_busy, b_ready}, want);
            end
            if (n < 45) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits1, bits2;
        logic [3:0]  want;
        bits1 = {1'b1, 1'b0, 8'h3C, 1'b0};
        bits2 = {1'b1, 1'b0, 8'hC3, 1'b0};
        a_data = 8'h3C; a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_data = 8'hC3;
        for (int n = 1; n <= 45; n++) begin
            if (n <= 44) want = {bits1[(n - 1) / 4], (n == 44), 1'b1, 1'b0};
            else         want = 4'b1001;
            tests++;
            if ({a_dout, a_done, a_busy, a_ready} !== want) begin
                fails++;
                $display("FAIL b2b_first cycle %0d: got %b required %b", n, {a_dout, a_done, a_busy, a_ready}, want);
            end
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0; a_data = 8'h00;
        for (int n = 1; n <= 45; n++) begin
            if (n <= 44) want = {bits2[(n - 1) / 4], (n == 44), 1'b1, 1'b0};
            else         want = 4'b1001;
            tests++;
            if ({a_dout, a_done, a_busy, a_ready} !== want) begin
                fails++;
                $display("FAIL b2b_second cycle %0d: got %b required %b", n, {a_dout, a_done, a_busy, a_ready}, want);
            end
            if (n < 45) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_data_toggle();
        logic [10:0] bits;
        logic [3:0]  want;
        bits = {1'b1, 1'b0, 8'h55, 1'b0};
        a_data = 8'h55; a_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 45; n++) begin
            if (n <= 44) want = {bits[(n - 1) / 4], (n == 44), 1'b1, 1'b0};
            else         want = 4'b1001;
            tests++;
            if ({a_dout, a_done, a_busy, a_ready} !== want) begin
                fails++;
                $display("FAIL toggle_55 cycle %0d: got %b required %b", n, {a_dout, a_done, a_busy, a_ready}, want);
            end
            a_data  = ~a_data;
            a_valid = (n < 44) ? ~a_valid : 1'b0;
            if (n < 45) begin
                @(posedge clk);
                #1;
            end
        end
        a_data = 8'h00;
    endtask

    task automatic test_reset_midframe();
        logic [3:0] want;
        a_data = 8'h96; a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        // Cycles 17..20 carry data bit 3; reset is sampled at the end of cycle 18.
        repeat (17) @(posedge clk);
        #1;
        tests++;
        if ({a_dout, a_busy} !== 2'b01) begin
            fails++;
            $display("FAIL midframe_bit3 cycle 18: got dout/busy %b required 01", {a_dout, a_busy});
        end
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            want = 4'b1000;
            tests++;
            if ({a_dout, a_done, a_busy, a_ready} !== want) begin
                fails++;
                $display("FAIL midframe_reset step %0d: got %b required %b", n, {a_dout, a_done, a_busy, a_ready}, want);
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 30; n++) begin
            want = 4'b1001;
            tests++;
            if ({a_dout, a_done, a_busy, a_ready} !== want) begin
                fails++;
                $display("FAIL midframe_after cycle %0d: got %b required %b", n, {a_dout, a_done, a_busy, a_ready}, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_one_clk_per_bit();
        logic [10:0] bits;
        logic [3:0]  want;
        bits = {1'b1, 1'b0, 8'hFF, 1'b0};
        c_data = 8'hFF; c_valid = 1'b1;
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (n <= 11) want = {bits[n - 1], (n == 11), 1'b1, 1'b0};
            else         want = 4'b1001;
            tests++;
            if ({c_dout, c_done, c_busy, c_ready} !== want) begin
                fails++;
                $display("FAIL cpb1_ff cycle %0d: got %b required %b", n, {c_dout, c_done, c_busy, c_ready}, want);
            end
            if (n < 12) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity_07();
        test_back_to_back();
        test_data_toggle();
        test_reset_midframe();
        test_one_clk_per_bit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
